// File: rtl/candle_array_controller.sv
// candle_array_controller: N candle outputs driven from one valid/ready command
// port. Supports set/clear/toggle, bulk set/clear and timed sequential lighting.
// Optional per-candle burn timers are built when CANDLE_BURN_TIMER_EN is defined;
// otherwise burn_time is ignored and burnout_pulse is tied low.

// One candle: on/off flag plus (optionally) its burn timer.
module candle_cell #(
  parameter int BURN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              light,
  input  logic              off,
  input  logic              tog,
  input  logic [BURN_W-1:0] burn,
  output logic              on,
  output logic              expire
);
`ifdef CANDLE_BURN_TIMER_EN
  logic [BURN_W-1:0] timer;

  // A command touching this candle overrides its expiry in the same cycle.
  assign expire = on && (timer == BURN_W'(1)) && !(light || off || tog);

  // Light events load the timer, clears zero it, otherwise count down to burnout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on    <= 1'b0;
      timer <= '0;
    end else if (light || (tog && !on)) begin
      on    <= 1'b1;
      timer <= burn;
    end else if (off || tog) begin
      on    <= 1'b0;
      timer <= '0;
    end else if (on && (timer != '0)) begin
      timer <= timer - BURN_W'(1);
      if (timer == BURN_W'(1)) on <= 1'b0;
    end
  end
`else
  logic burn_unused;
  assign burn_unused = ^burn;
  assign expire      = 1'b0;

  // Plain on/off latch; candles stay lit until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     on <= 1'b0;
    else if (light)              on <= 1'b1;
    else if (off)                on <= 1'b0;
    else if (tog)                on <= ~on;
  end
`endif
endmodule

module candle_array_controller #(
  parameter int N_CANDLES   = 8,
  parameter int BURN_W      = 16,
  parameter int STEP_CYCLES = 4
) (
  input  logic                         sys_clk,
  input  logic                         clr_async,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [$clog2(N_CANDLES)-1:0] cmd_pos,
  input  logic [BURN_W-1:0]            burn_time,
  output logic [N_CANDLES-1:0]         candle_state,
  output logic                         seq_busy,
  output logic                         burnout_pulse,
  output logic [$clog2(N_CANDLES+1)-1:0] lit_count
);
  localparam int PW  = $clog2(N_CANDLES);
  localparam int CW  = $clog2(N_CANDLES + 1);
  localparam int SCW = $clog2(STEP_CYCLES + 1);
  localparam logic [SCW-1:0] STEP_LD = SCW'(STEP_CYCLES - 1);

  localparam logic [2:0] OP_SET = 3'd1, OP_CLR = 3'd2, OP_TOG = 3'd3,
                         OP_SETA = 3'd4, OP_CLRA = 3'd5, OP_SEQ = 3'd6;

  typedef enum logic {IDLE, SEQ} state_t;

  state_t          state;
  logic [PW-1:0]   cur, last, nxt, seq_last;
  logic [SCW-1:0]  cnt;
  logic            done, accept, seq_fire;
  logic [BURN_W-1:0]    burn_sel;
  logic [N_CANDLES-1:0] light, off, tog, expire;

  assign accept   = cmd_valid && cmd_ready;
  assign seq_fire = (state == SEQ) && !done && (cnt == '0);
  assign nxt      = cur + PW'(1);
  // Out-of-range sequence targets clamp to the last real candle.
  assign seq_last = (int'(cmd_pos) >= N_CANDLES) ? PW'(N_CANDLES - 1) : cmd_pos;

  // Sequence FSM: candle 0 lights on acceptance, then one more every STEP_CYCLES;
  // stays in SEQ for the cycle the last candle lights, then returns to IDLE.
  always_ff @(posedge sys_clk or posedge clr_async) begin
    if (clr_async) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      seq_busy  <= 1'b0;
      cur       <= '0;
      last      <= '0;
      cnt       <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept && cmd_op == OP_SEQ) begin
          state     <= SEQ;
          cmd_ready <= 1'b0;
          seq_busy  <= 1'b1;
          cur       <= '0;
          last      <= seq_last;
          cnt       <= STEP_LD;
          done      <= (seq_last == '0);
        end
        SEQ: begin
          if (done) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            seq_busy  <= 1'b0;
          end else if (cnt == '0) begin
            cur  <= nxt;
            cnt  <= STEP_LD;
            done <= (nxt == last);
          end else begin
            cnt <= cnt - SCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CANDLE_BURN_TIMER_EN
  logic [BURN_W-1:0] seq_burn;

  // Sequence lights use the burn time captured when the sequence was accepted.
  always_ff @(posedge sys_clk or posedge clr_async) begin
    if (clr_async)                                      seq_burn <= '0;
    else if (state == IDLE && accept && cmd_op == OP_SEQ) seq_burn <= burn_time;
  end
  assign burn_sel = (state == SEQ) ? seq_burn : burn_time;

  // Any number of simultaneous burnouts collapse into one pulse.
  always_ff @(posedge sys_clk or posedge clr_async) begin
    if (clr_async) burnout_pulse <= 1'b0;
    else           burnout_pulse <= |expire;
  end
`else
  logic burn_unused, expire_unused;
  assign burn_unused   = ^burn_time;
  assign expire_unused = |expire;
  assign burn_sel      = '0;
  assign burnout_pulse = 1'b0;
`endif

  for (genvar i = 0; i < N_CANDLES; i++) begin : g_cell
    logic hit;
    assign hit      = accept && (cmd_pos == PW'(i));
    assign light[i] = (hit && cmd_op == OP_SET) || (accept && cmd_op == OP_SETA) ||
                      (i == 0 && accept && cmd_op == OP_SEQ) ||
                      (seq_fire && nxt == PW'(i));
    assign off[i]   = (hit && cmd_op == OP_CLR) || (accept && cmd_op == OP_CLRA);
    assign tog[i]   = hit && cmd_op == OP_TOG;

    candle_cell #(.BURN_W(BURN_W)) u_cell (
      .clk(sys_clk), .rst(clr_async), .light(light[i]), .off(off[i]), .tog(tog[i]),
      .burn(burn_sel), .on(candle_state[i]), .expire(expire[i])
    );
  end

  // Population count of the lit candles.
  always_comb begin
    lit_count = '0;
    for (int i = 0; i < N_CANDLES; i++)
      if (candle_state[i]) lit_count = lit_count + CW'(1);
  end
endmodule
